// File: rtl/reg_seq_if.sv
// ============================================================================
// Module      : reg_seq_if
// Description : Command, response and register-file bus bundle for reg_seq.
//               The slave modport is the sequencer side; the master modport
//               is the side that issues commands and owns the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_seq_if;
  // Command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_dst;
  logic [2:0] cmd_src;
  logic [7:0] cmd_imm;
  // READ response channel
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  // Register-file access
  logic [2:0] rf_sel_in;
  logic [2:0] rf_sel_out;
  logic [7:0] rf_data_in;
  logic       rf_we;
  logic       rf_oe;
  logic [7:0] rf_data_out;
  // Status
  logic       busy;
  logic       err;
  logic       err_clr;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    input  rsp_ready, rf_data_out, err_clr,
    output cmd_ready, rsp_valid, rsp_data,
    output rf_sel_in, rf_sel_out, rf_data_in, rf_we, rf_oe,
    output busy, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
    output rsp_ready, rf_data_out, err_clr,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rf_sel_in, rf_sel_out, rf_data_in, rf_we, rf_oe,
    input  busy, err
  );
endinterface

`default_nettype wire

// File: rtl/reg_seq.sv
// ============================================================================
// Module      : reg_seq
// Description : Register-file sequencer. Accepts one command at a time and
//               drives an external 8x8 register file to perform LDI, READ,
//               MOV, SWAP (through a scratch register) and CLR. Illegal
//               commands raise a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_seq #(
  parameter logic [2:0] TEMP_REG = 3'd7,
  parameter logic [7:0] CLR_VAL  = 8'h00
) (
  input  wire logic clk,
  input  wire logic rst_n,
  reg_seq_if.slave  bus
);

  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;
  localparam logic [2:0] OP_MOV  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RSP  = 3'd3,
    S_SW1  = 3'd4,
    S_SW2  = 3'd5,
    S_SW3  = 3'd6,
    S_CLR  = 3'd7
  } state_t;

  state_t     r_state;
  logic [2:0] r_dst;
  logic [2:0] r_src;
  logic       r_is_read;
  logic [2:0] r_cnt;
  logic       r_we;
  logic       r_oe;
  logic [2:0] r_sel_in;
  logic [2:0] r_sel_out;
  logic [7:0] r_wdata;
  logic       r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_err;

  logic w_accept;
  logic w_swap_bad;
  logic w_err_set;
  logic w_sw;

  // A SWAP touching the scratch register would destroy its own operand.
  assign w_accept   = bus.cmd_valid && (r_state == S_IDLE);
  assign w_swap_bad = (bus.cmd_src == TEMP_REG) || (bus.cmd_dst == TEMP_REG);
  assign w_err_set  = w_accept &&
                      (((bus.cmd_op == OP_SWAP) && w_swap_bad) ||
                       (bus.cmd_op[2] && bus.cmd_op[1]));
  assign w_sw       = (r_state == S_SW1) || (r_state == S_SW2) ||
                      (r_state == S_SW3);

  // Sequencer: each transition also loads the rf controls for the next state,
  // so rf_we/rf_oe/selects are registered and zero whenever not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dst       <= 3'd0;
      r_src       <= 3'd0;
      r_is_read   <= 1'b0;
      r_cnt       <= 3'd0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_sel_in    <= 3'd0;
      r_sel_out   <= 3'd0;
      r_wdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_sel_in  <= 3'd0;
      r_sel_out <= 3'd0;
      r_wdata   <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_dst     <= bus.cmd_dst;
            r_src     <= bus.cmd_src;
            r_is_read <= (bus.cmd_op == OP_READ);
            r_cnt     <= 3'd0;
            case (bus.cmd_op)
              OP_LDI: begin
                r_state  <= S_WR;
                r_we     <= 1'b1;
                r_sel_in <= bus.cmd_dst;
                r_wdata  <= bus.cmd_imm;
              end
              OP_READ, OP_MOV: begin
                r_state   <= S_RD;
                r_oe      <= 1'b1;
                r_sel_out <= bus.cmd_src;
              end
              OP_SWAP: begin
                if (!w_swap_bad) begin
                  r_state   <= S_SW1;
                  r_we      <= 1'b1;
                  r_oe      <= 1'b1;
                  r_sel_in  <= TEMP_REG;
                  r_sel_out <= bus.cmd_src;
                end
              end
              OP_CLR: begin
                r_state  <= S_CLR;
                r_we     <= 1'b1;
                r_sel_in <= 3'd0;
                r_wdata  <= CLR_VAL;
              end
              default: ;
            endcase
          end
        end
        S_RD: begin
          if (r_is_read) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= bus.rf_data_out;
          end else begin
            r_state  <= S_WR;
            r_we     <= 1'b1;
            r_sel_in <= r_dst;
            r_wdata  <= bus.rf_data_out;
          end
        end
        S_WR: r_state <= S_IDLE;
        S_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_SW1: begin
          r_state   <= S_SW2;
          r_we      <= 1'b1;
          r_oe      <= 1'b1;
          r_sel_out <= r_dst;
          r_sel_in  <= r_src;
        end
        S_SW2: begin
          r_state   <= S_SW3;
          r_we      <= 1'b1;
          r_oe      <= 1'b1;
          r_sel_out <= TEMP_REG;
          r_sel_in  <= r_dst;
        end
        S_SW3: r_state <= S_IDLE;
        S_CLR: begin
          if (r_cnt == 3'd7) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt    <= r_cnt + 3'd1;
            r_we     <= 1'b1;
            r_sel_in <= r_cnt + 3'd1;
            r_wdata  <= CLR_VAL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flag; a new illegal command outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

  // SWAP copies straight through: read data of this cycle is the write data.
  assign bus.rf_data_in = w_sw ? bus.rf_data_out : r_wdata;
  assign bus.rf_we      = r_we;
  assign bus.rf_oe      = r_oe;
  assign bus.rf_sel_in  = r_sel_in;
  assign bus.rf_sel_out = r_sel_out;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err        = r_err;
  assign bus.cmd_ready  = (r_state == S_IDLE) && rst_n;

endmodule

`default_nettype wire

// File: doc/reg_seq.md
REG_SEQ -- requirements
Module: reg_seq

Interface
REQ-001 SHALL have parameter TEMP_REG, default 3'd7, scratch register used by SWAP.
REQ-002 SHALL have parameter CLR_VAL, default 8'h00, value written by CLR.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 cmd_op  input  3  0 NOP, 1 LDI, 2 READ, 3 MOV, 4 SWAP, 5 CLR, 6-7 illegal.
REQ-009 cmd_dst  input  3  destination register index.
REQ-010 cmd_src  input  3  source register index.
REQ-011 cmd_imm  input  8  LDI immediate.
REQ-012 rsp_valid  output  1  READ result valid.
REQ-013 rsp_ready  input  1  READ result consumed.
REQ-014 rsp_data  output  8  READ result.
REQ-015 rf_sel_in  output  3  register-file write index.
REQ-016 rf_sel_out  output  3  register-file read index.
REQ-017 rf_data_in  output  8  register-file write data.
REQ-018 rf_we  output  1  register-file write enable (write lands at next rising edge).
REQ-019 rf_oe  output  1  register-file output enable.
REQ-020 rf_data_out  input  8  register-file read data, combinational from rf_sel_out.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 err  output  1  sticky illegal-command flag.
REQ-023 err_clr  input  1  synchronous clear of err.

Function
REQ-024 FSM states SHALL be IDLE, RD, WR, RSP, SW1, SW2, SW3, CLR; cmd_ready SHALL be 1 only in IDLE with rst_n high.
REQ-025 On acceptance in cycle N, cmd fields SHALL be registered; execution starts in cycle N+1.
REQ-026 NOP SHALL return to IDLE at N+1 with no rf_we/rf_oe activity.
REQ-027 LDI: WR at N+1 (rf_we=1, rf_sel_in=dst, rf_data_in=imm); IDLE at N+2.
REQ-028 READ: RD at N+1 (rf_oe=1, rf_sel_out=src, rf_data_out captured); RSP from N+2 with rsp_valid=1 and rsp_data stable until the cycle rsp_valid&&rsp_ready, then IDLE.
REQ-029 MOV: RD at N+1 captures src; WR at N+2 writes captured value to dst; IDLE at N+3.
REQ-030 SWAP: SW1 writes src to TEMP_REG; SW2 writes dst value to src; SW3 writes TEMP_REG value to dst; each cycle rf_oe=1 and rf_data_in=rf_data_out; IDLE at N+4.
REQ-031 SWAP with src or dst equal to TEMP_REG SHALL be illegal: err set, no rf writes, IDLE at N+1.
REQ-032 SWAP with src==dst SHALL execute normally (register unchanged, TEMP_REG overwritten).
REQ-033 CLR: 3-bit counter writes CLR_VAL to registers 0..7 in ascending order, one per cycle, N+1..N+8; IDLE at N+9.
REQ-034 Ops 6-7 SHALL be accepted, set err, perform no rf access, IDLE at N+1.
REQ-035 err SHALL clear on err_clr; if set and clear coincide, set wins.
REQ-036 rf_we and rf_oe SHALL be 0 in every state/cycle not listed above; rf_sel_in, rf_sel_out, rf_data_in SHALL be 0 when their enables are 0.
REQ-037 Outputs SHALL be registered or decoded from state/registered fields only, except rf_data_in in SW states and cmd_ready's rst_n term.

Reset
REQ-038 rst_n low SHALL immediately force IDLE, rsp_valid=0, rsp_data=0, rf_we=0, rf_oe=0, all rf selects/data 0, busy=0, err=0, cmd_ready=0, CLR counter 0.
REQ-039 Reset mid-operation SHALL abort: no further writes; writes already completed remain.

Verification
REQ-040 LDI dst=3 imm=8'hA5, then READ src=3 -> rf_we one cycle at N+1 with sel_in=3; rsp_data=8'hA5, rsp_valid at N+2.
REQ-041 r1=8'h11, r2=8'h22, SWAP src=1 dst=2 -> r1=8'h22, r2=8'h11, r7=8'h11; cmd_ready high again at N+4.
REQ-042 READ with rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, no rf activity until handshake.
REQ-043 cmd_op=6, then SWAP src=7 dst=0 -> err=1, zero rf_we pulses; err_clr asserted with a new illegal op -> err stays 1.
REQ-044 CLR after loading all registers with 8'hFF -> eight rf_we pulses, sel_in 0..7; rst_n pulled low after third write -> r0-r2=0, r3-r7=8'hFF, state IDLE.
